keypad_matrix_responder: RTL and testbench

- Emulates the 4x3 telephone keypad matrix at the far end of the column-scan interface.
- The scanner drives key_col; this block returns key_row for the key currently "pressed".
- Presses are scripted through a valid/ready command port, with programmable hold, gap and optional contact bounce.
- Used for on-board self-test and for closed-loop verification of the keypad scanner and game logic without a physical keypad.

---
 rtl/keypad_matrix_responder_if.sv | 24 ++
 rtl/keypad_matrix_responder.sv | 193 +++++++++++++++++++
 tb/tb_keypad_matrix_responder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_responder_if.sv
// Command port of the keypad matrix responder: a valid/ready press request
// plus the status pulses that report how the scripted press progresses.
interface keypad_matrix_responder_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_key;
   logic [7:0] cmd_hold;
   logic [7:0] cmd_gap;
   logic       busy;
   logic       done;
   logic       cmd_err;

   // Side that scripts key presses (scanner test harness, self-test sequencer)
   modport master (
      output cmd_valid, cmd_key, cmd_hold, cmd_gap,
      input  cmd_ready, busy, done, cmd_err
   );

   // Side that plays the keypad
   modport slave (
      input  cmd_valid, cmd_key, cmd_hold, cmd_gap,
      output cmd_ready, busy, done, cmd_err
   );
endinterface

// File: rtl/keypad_matrix_responder.sv
// Emulates a 4x3 telephone keypad behind a column-scan interface.
// A scripted press runs bounce-in, hold, bounce-out and gap phases, each an
// exact number of timing ticks; during contact the pressed key's row line
// follows the column strobe driven by the scanner.
module keypad_matrix_responder #(
   parameter int unsigned TICK_DIV     = 12500,
   parameter int unsigned BOUNCE_TICKS = 4,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [2:0]                     key_col,
   output logic [3:0]                     key_row,
   keypad_matrix_responder_if.slave       cmd
);

   localparam int unsigned      CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
   localparam logic [7:0]       BOUNCE_LEN = 8'(BOUNCE_TICKS);

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] tick_cnt;
   logic [7:0]       ticks_left;
   logic [7:0]       hold_q;
   logic [7:0]       gap_q;
   logic [7:0]       lfsr;
   logic [7:0]       lfsr_next;
   logic [3:0]       key_q;
   logic             legal_q;
   logic             contact;
   logic             done_q;
   logic             err_q;
   logic             accept;
   logic             tick;
   logic             key_legal;
   logic [3:0]       row_sel;
   logic [2:0]       col_mask;

   assign cmd.cmd_ready = (state == IDLE);
   assign cmd.busy      = (state != IDLE);
   assign cmd.done      = done_q;
   assign cmd.cmd_err   = err_q;

   assign accept    = cmd.cmd_valid && (state == IDLE);
   assign tick      = (tick_cnt == CNT_LAST);
   assign key_legal = (cmd.cmd_key <= 4'd11);
   assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   // Decode the latched key into its row line and the column that carries it
   always_comb begin
      row_sel  = 4'b0000;
      col_mask = 3'b000;
      case (key_q)
         4'd1, 4'd2, 4'd3:   row_sel = 4'b0001;
         4'd4, 4'd5, 4'd6:   row_sel = 4'b0010;
         4'd7, 4'd8, 4'd9:   row_sel = 4'b0100;
         4'd0, 4'd10, 4'd11: row_sel = 4'b1000;
         default:            row_sel = 4'b0000;
      endcase
      case (key_q)
         4'd1, 4'd4, 4'd7, 4'd10: col_mask = 3'b001;
         4'd2, 4'd5, 4'd8, 4'd0:  col_mask = 3'b010;
         4'd3, 4'd6, 4'd9, 4'd11: col_mask = 3'b100;
         default:                 col_mask = 3'b000;
      endcase
   end

   // Row return is purely combinational so the scanner sees its own strobe echoed within the cycle
   always_comb begin
      key_row = 4'b0000;
      if (contact && ((key_col & col_mask) != 3'b000)) begin
         key_row = row_sel;
      end
   end

   // Press sequencer: tick divider, phase counter, bounce LFSR and registered contact/status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tick_cnt   <= '0;
         ticks_left <= 8'd0;
         hold_q     <= 8'd0;
         gap_q      <= 8'd0;
         key_q      <= 4'd0;
         legal_q    <= 1'b0;
         lfsr       <= LFSR_SEED;
         contact    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         if (state == IDLE || tick) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  key_q   <= cmd.cmd_key;
                  hold_q  <= cmd.cmd_hold;
                  gap_q   <= cmd.cmd_gap;
                  legal_q <= key_legal;
                  err_q   <= !key_legal;
                  if (BOUNCE_TICKS == 0) begin
                     state      <= HOLD;
                     ticks_left <= (cmd.cmd_hold == 8'd0) ? 8'd1 : cmd.cmd_hold;
                     contact    <= key_legal;
                  end else begin
                     state      <= BOUNCE_IN;
                     ticks_left <= BOUNCE_LEN;
                     contact    <= key_legal && lfsr[0];
                  end
               end
            end

            BOUNCE_IN, BOUNCE_OUT: begin
               if (tick) begin
                  lfsr <= lfsr_next;
                  if (ticks_left == 8'd1) begin
                     if (state == BOUNCE_IN) begin
                        state      <= HOLD;
                        ticks_left <= (hold_q == 8'd0) ? 8'd1 : hold_q;
                        contact    <= legal_q;
                     end else if (gap_q == 8'd0) begin
                        state   <= IDLE;
                        done_q  <= 1'b1;
                        contact <= 1'b0;
                     end else begin
                        state      <= GAP;
                        ticks_left <= gap_q;
                        contact    <= 1'b0;
                     end
                  end else begin
                     ticks_left <= ticks_left - 8'd1;
                     contact    <= legal_q && lfsr_next[0];
                  end
               end
            end

            HOLD: begin
               if (tick) begin
                  if (ticks_left == 8'd1) begin
                     if (BOUNCE_TICKS != 0) begin
                        state      <= BOUNCE_OUT;
                        ticks_left <= BOUNCE_LEN;
                        contact    <= legal_q && lfsr[0];
                     end else if (gap_q == 8'd0) begin
                        state   <= IDLE;
                        done_q  <= 1'b1;
                        contact <= 1'b0;
                     end else begin
                        state      <= GAP;
                        ticks_left <= gap_q;
                        contact    <= 1'b0;
                     end
                  end else begin
                     ticks_left <= ticks_left - 8'd1;
                  end
               end
            end

            GAP: begin
               if (tick) begin
                  if (ticks_left == 8'd1) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end else begin
                     ticks_left <= ticks_left - 8'd1;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               contact <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Bench for keypad_matrix_responder: a fast no-bounce instance covers the
// directed scenarios, a bouncing instance covers the LFSR chatter, and both
// get randomized presses checked against a per-cycle expected contact trace.
module tb_keypad_matrix_responder;

   localparam int TD_A = 4;
   localparam int TD_B = 2;
   localparam int BT_B = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] col_a;
   logic [2:0] col_b;
   logic [3:0] row_a;
   logic [3:0] row_b;

   int compared   = 0;
   int mismatched = 0;

   bit         use_b = 1'b0;
   bit         trace_q[$];
   logic [7:0] model_lfsr;

   logic [3:0] obs_row;
   logic       obs_busy;
   logic       obs_ready;
   logic       obs_done;
   logic       obs_err;

   keypad_matrix_responder_if if_a ();
   keypad_matrix_responder_if if_b ();

   keypad_matrix_responder #(.TICK_DIV(TD_A), .BOUNCE_TICKS(0), .LFSR_SEED(8'hA5)) dut_a (
      .clk     (clk),
      .rst     (rst),
      .key_col (col_a),
      .key_row (row_a),
      .cmd     (if_a.slave)
   );

   keypad_matrix_responder #(.TICK_DIV(TD_B), .BOUNCE_TICKS(BT_B), .LFSR_SEED(8'hA5)) dut_b (
      .clk     (clk),
      .rst     (rst),
      .key_col (col_b),
      .key_row (row_b),
      .cmd     (if_b.slave)
   );

   always #5 clk = ~clk;

   assign obs_row   = use_b ? row_b : row_a;
   assign obs_busy  = use_b ? if_b.busy : if_a.busy;
   assign obs_ready = use_b ? if_b.cmd_ready : if_a.cmd_ready;
   assign obs_done  = use_b ? if_b.done : if_a.done;
   assign obs_err   = use_b ? if_b.cmd_err : if_a.cmd_err;

   // Keypad layout as arithmetic: digits 1-9 fill rows 0-2 left to right, bottom row is * 0 #
   function automatic logic [3:0] exp_row(input logic [3:0] key, input logic [2:0] col, input bit contact);
      int k;
      int r;
      int c;
      k = int'(key);
      if (!contact || k > 11) return 4'b0000;
      if (k == 0) begin
         r = 3; c = 1;
      end else if (k == 10) begin
         r = 3; c = 0;
      end else if (k == 11) begin
         r = 3; c = 2;
      end else begin
         r = (k - 1) / 3;
         c = (k - 1) % 3;
      end
      return col[c] ? 4'(1 << r) : 4'b0000;
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      int fb;
      fb = (int'(v[7]) + int'(v[5]) + int'(v[4]) + int'(v[3])) % 2;
      return 8'(((int'(v) * 2) % 256) + fb);
   endfunction

   // Expected contact level for every busy cycle after the accept edge
   task automatic build_trace(input int td, input int bt, input int hold, input int gap);
      int h;
      trace_q.delete();
      h = (hold == 0) ? 1 : hold;
      for (int t = 0; t < bt; t++) begin
         for (int c = 0; c < td; c++) trace_q.push_back(model_lfsr[0]);
         model_lfsr = lfsr_step(model_lfsr);
      end
      for (int t = 0; t < h * td; t++) trace_q.push_back(1'b1);
      for (int t = 0; t < bt; t++) begin
         for (int c = 0; c < td; c++) trace_q.push_back(model_lfsr[0]);
         model_lfsr = lfsr_step(model_lfsr);
      end
      for (int t = 0; t < gap * td; t++) trace_q.push_back(1'b0);
   endtask

   task automatic drive(input logic v, input logic [3:0] k, input logic [7:0] h, input logic [7:0] g);
      if (use_b) begin
         if_b.cmd_valid = v; if_b.cmd_key = k; if_b.cmd_hold = h; if_b.cmd_gap = g;
      end else begin
         if_a.cmd_valid = v; if_a.cmd_key = k; if_a.cmd_hold = h; if_a.cmd_gap = g;
      end
   endtask

   task automatic set_col(input logic [2:0] c);
      col_a = c;
      col_b = c;
   endtask

   task automatic test_reset();
      set_col(3'b111);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      compared++; if (row_a !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_row_a got %b want 0000", row_a); end
      compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_a got %b want 0", if_a.busy); end
      compared++; if (if_a.cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready_a got %b want 1", if_a.cmd_ready); end
      compared++; if (if_a.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done_a got %b want 0", if_a.done); end
      compared++; if (if_a.cmd_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err_a got %b want 0", if_a.cmd_err); end
      compared++; if (row_b !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_row_b got %b want 0000", row_b); end
      compared++; if (if_b.cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready_b got %b want 1", if_b.cmd_ready); end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_busy_a got %b want 0", if_a.busy); end
      compared++; if (if_b.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_busy_b got %b want 0", if_b.busy); end
   endtask

   task automatic test_basic_press();
      logic [3:0] exp_r;
      use_b = 1'b0;
      set_col(3'b010);
      drive(1'b1, 4'd5, 8'd3, 8'd2);
      @(posedge clk);
      #1 drive(1'b0, 4'd0, 8'd0, 8'd0);
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         exp_r = (i < 12) ? 4'b0010 : 4'b0000;
         compared++; if (row_a !== exp_r) begin mismatched++; $display("[TB] FAIL basic_row cyc%0d got %b want %b", i, row_a, exp_r); end
         compared++; if (if_a.done !== 1'(i == 20)) begin mismatched++; $display("[TB] FAIL basic_done cyc%0d got %b want %b", i, if_a.done, i == 20); end
         compared++; if (if_a.cmd_ready !== 1'(i == 20)) begin mismatched++; $display("[TB] FAIL basic_ready cyc%0d got %b want %b", i, if_a.cmd_ready, i == 20); end
      end
   endtask

   task automatic test_column_sweep();
      logic [3:0] keys [3];
      logic [2:0] cols [4];
      logic [3:0] want [3][4];
      keys = '{4'd11, 4'd0, 4'd1};
      cols = '{3'b001, 3'b010, 3'b100, 3'b000};
      want = '{'{4'b0000, 4'b0000, 4'b1000, 4'b0000},
               '{4'b0000, 4'b1000, 4'b0000, 4'b0000},
               '{4'b0001, 4'b0000, 4'b0000, 4'b0000}};
      use_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, keys[k], 8'd4, 8'd0);
         @(posedge clk);
         #1 drive(1'b0, 4'd0, 8'd0, 8'd0);
         for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
               @(posedge clk);
               #1;
            end
            set_col(cols[i % 4]);
            @(negedge clk);
            if (i < 16) begin
               compared++;
               if (row_a !== want[k][i % 4]) begin
                  mismatched++;
                  $display("[TB] FAIL sweep_row key%0d col%b got %b want %b", keys[k], cols[i % 4], row_a, want[k][i % 4]);
               end
            end else begin
               compared++; if (if_a.done !== 1'b1) begin mismatched++; $display("[TB] FAIL sweep_done key%0d got %b want 1", keys[k], if_a.done); end
            end
         end
      end
   endtask

   task automatic test_illegal_key();
      logic [2:0] cols [4];
      cols = '{3'b001, 3'b010, 3'b100, 3'b111};
      use_b = 1'b0;
      drive(1'b1, 4'd13, 8'd2, 8'd1);
      @(posedge clk);
      #1 drive(1'b0, 4'd0, 8'd0, 8'd0);
      for (int i = 0; i <= 12; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         set_col(cols[i % 4]);
         @(negedge clk);
         compared++; if (row_a !== 4'b0000) begin mismatched++; $display("[TB] FAIL illegal_row cyc%0d got %b want 0000", i, row_a); end
         compared++; if (if_a.cmd_err !== 1'(i == 0)) begin mismatched++; $display("[TB] FAIL illegal_err cyc%0d got %b want %b", i, if_a.cmd_err, i == 0); end
         compared++; if (if_a.done !== 1'(i == 12)) begin mismatched++; $display("[TB] FAIL illegal_done cyc%0d got %b want %b", i, if_a.done, i == 12); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_r;
      use_b = 1'b0;
      set_col(3'b110);
      drive(1'b1, 4'd2, 8'd1, 8'd1);
      @(posedge clk);
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         exp_r = (i < 4) ? 4'b0001 : 4'b0000;
         compared++; if (row_a !== exp_r) begin mismatched++; $display("[TB] FAIL b2b_first_row cyc%0d got %b want %b", i, row_a, exp_r); end
         compared++; if (if_a.cmd_ready !== 1'(i == 8)) begin mismatched++; $display("[TB] FAIL b2b_first_ready cyc%0d got %b want %b", i, if_a.cmd_ready, i == 8); end
         compared++; if (if_a.busy !== 1'(i < 8)) begin mismatched++; $display("[TB] FAIL b2b_first_busy cyc%0d got %b want %b", i, if_a.busy, i < 8); end
         drive(1'b1, 4'd3, 8'd1, 8'd0);
         if (i < 8) @(posedge clk);
      end
      compared++; if (if_a.done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_first_done got %b want 1", if_a.done); end
      @(posedge clk);
      #1 drive(1'b0, 4'd0, 8'd0, 8'd0);
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         exp_r = (i < 4) ? 4'b0001 : 4'b0000;
         compared++; if (row_a !== exp_r) begin mismatched++; $display("[TB] FAIL b2b_second_row cyc%0d got %b want %b", i, row_a, exp_r); end
         compared++; if (if_a.busy !== 1'(i < 4)) begin mismatched++; $display("[TB] FAIL b2b_second_busy cyc%0d got %b want %b", i, if_a.busy, i < 4); end
         compared++; if (if_a.done !== 1'(i == 4)) begin mismatched++; $display("[TB] FAIL b2b_second_done cyc%0d got %b want %b", i, if_a.done, i == 4); end
         if (i < 4) @(posedge clk);
      end
   endtask

   task automatic test_reset_mid_hold();
      use_b = 1'b0;
      set_col(3'b001);
      drive(1'b1, 4'd1, 8'd4, 8'd2);
      @(posedge clk);
      #1 drive(1'b0, 4'd0, 8'd0, 8'd0);
      repeat (3) @(negedge clk);
      compared++; if (row_a !== 4'b0001) begin mismatched++; $display("[TB] FAIL midreset_pre_row got %b want 0001", row_a); end
      #1 rst = 1'b0;
      #1;
      compared++; if (row_a !== 4'b0000) begin mismatched++; $display("[TB] FAIL midreset_async_row got %b want 0000", row_a); end
      compared++; if (if_a.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy got %b want 0", if_a.busy); end
      compared++; if (if_a.cmd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_ready got %b want 1", if_a.cmd_ready); end
      #1 rst = 1'b1;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         compared++;
         if (if_a.done !== 1'b0 || if_a.busy !== 1'b0 || row_a !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL midreset_after cyc%0d done %b busy %b row %b want 0 0 0000", i, if_a.done, if_a.busy, row_a);
         end
      end
   endtask

   task automatic test_bounce();
      logic [7:0] holds [2];
      logic [7:0] gaps [2];
      logic [3:0] exp_r;
      int len;
      holds = '{8'd2, 8'd1};
      gaps  = '{8'd2, 8'd0};
      use_b = 1'b1;
      model_lfsr = 8'hA5;
      set_col(3'b010);
      for (int n = 0; n < 2; n++) begin
         build_trace(TD_B, BT_B, int'(holds[n]), int'(gaps[n]));
         len = trace_q.size();
         drive(1'b1, 4'd8, holds[n], gaps[n]);
         @(posedge clk);
         #1 drive(1'b0, 4'd0, 8'd0, 8'd0);
         for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            exp_r = exp_row(4'd8, col_b, (i < len) ? trace_q[i] : 1'b0);
            compared++; if (row_b !== exp_r) begin mismatched++; $display("[TB] FAIL bounce_row press%0d cyc%0d got %b want %b", n, i, row_b, exp_r); end
            compared++; if (if_b.done !== 1'(i == len)) begin mismatched++; $display("[TB] FAIL bounce_done press%0d cyc%0d got %b want %b", n, i, if_b.done, i == len); end
            if (i < len) @(posedge clk);
         end
      end
   endtask

   task automatic test_random(input int iters, input string tag);
      int td;
      int bt;
      int len;
      logic [3:0] key;
      logic [7:0] hold;
      logic [7:0] gap;
      logic [3:0] exp_r;
      td = use_b ? TD_B : TD_A;
      bt = use_b ? BT_B : 0;
      for (int n = 0; n < iters; n++) begin
         key  = 4'($urandom_range(0, 15));
         hold = 8'($urandom_range(0, 4));
         gap  = 8'($urandom_range(0, 3));
         build_trace(td, bt, int'(hold), int'(gap));
         len = trace_q.size();
         drive(1'b1, key, hold, gap);
         @(posedge clk);
         for (int i = 0; i <= len; i++) begin
            #1;
            set_col(3'($urandom_range(0, 7)));
            drive((i < len) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            @(negedge clk);
            exp_r = exp_row(key, col_a, (i < len) ? trace_q[i] : 1'b0);
            compared++; if (obs_row !== exp_r) begin mismatched++; $display("[TB] FAIL %s_row it%0d cyc%0d key%0d col%b got %b want %b", tag, n, i, key, col_a, obs_row, exp_r); end
            compared++; if (obs_busy !== 1'(i < len)) begin mismatched++; $display("[TB] FAIL %s_busy it%0d cyc%0d got %b want %b", tag, n, i, obs_busy, i < len); end
            compared++; if (obs_ready !== 1'(i == len)) begin mismatched++; $display("[TB] FAIL %s_ready it%0d cyc%0d got %b want %b", tag, n, i, obs_ready, i == len); end
            compared++; if (obs_done !== 1'(i == len)) begin mismatched++; $display("[TB] FAIL %s_done it%0d cyc%0d got %b want %b", tag, n, i, obs_done, i == len); end
            compared++; if (obs_err !== 1'(i == 0 && key > 4'd11)) begin mismatched++; $display("[TB] FAIL %s_err it%0d cyc%0d got %b want %b", tag, n, i, obs_err, (i == 0 && key > 4'd11)); end
            if (i < len) @(posedge clk);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      set_col(3'b000);
      if_a.cmd_valid = 1'b0; if_a.cmd_key = 4'd0; if_a.cmd_hold = 8'd0; if_a.cmd_gap = 8'd0;
      if_b.cmd_valid = 1'b0; if_b.cmd_key = 4'd0; if_b.cmd_hold = 8'd0; if_b.cmd_gap = 8'd0;
      $display("[TB] keypad_matrix_responder bench starting");
      test_reset();
      test_basic_press();
      test_column_sweep();
      test_illegal_key();
      test_back_to_back();
      test_reset_mid_hold();
      use_b = 1'b0;
      test_random(40, "rand_a");
      test_bounce();
      use_b = 1'b1;
      test_random(40, "rand_b");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
